// File: rtl/fir_switch_sequencer_if.sv
// Switch/frame handshake bundle between the board-side driver
// and the filter-selection sequencer.
interface fir_switch_sequencer_if #(
    parameter int N_FILTERS = 4
);
    logic [N_FILTERS-1:0] sw_raw;
    logic                 frame_done;
    logic [N_FILTERS-1:0] sw_sel;
    logic                 mute;
    logic                 sel_update;
    logic                 busy;

    modport master (
        output sw_raw,
        output frame_done,
        input  sw_sel,
        input  mute,
        input  sel_update,
        input  busy
    );

    modport slave (
        input  sw_raw,
        input  frame_done,
        output sw_sel,
        output mute,
        output sel_update,
        output busy
    );
endinterface

// File: rtl/fir_switch_sequencer.sv
// Debounces filter-select switches and swaps the FIR selection
// only at frame boundaries, wrapped in a fixed-length mute window.
module fir_switch_sequencer #(
    parameter int N_FILTERS       = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MUTE_FRAMES     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_switch_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int FW = $clog2(MUTE_FRAMES + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] F_MAX  = FW'(MUTE_FRAMES - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ARM  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [N_FILTERS-1:0] sync1;
    logic [N_FILTERS-1:0] sw_sync;
    logic [N_FILTERS-1:0] cand;
    logic [N_FILTERS-1:0] stable;
    logic [N_FILTERS-1:0] sw_sel;
    logic [DW-1:0]        db_cnt;
    logic [FW-1:0]        f_cnt;
    logic                 mute;
    logic                 sel_update;
    logic                 pending;
    logic                 do_swap;
    logic                 do_unmute;
    logic                 do_count;

    assign pending = (stable != sw_sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sw_sync <= '0;
        end else begin
            sync1   <= bus.sw_raw;
            sw_sync <= sync1;
        end
    end

    // db_cnt saturates so a held value keeps re-asserting stable
    always_ff @(posedge clk) begin
        if (reset) begin
            cand   <= '0;
            db_cnt <= '0;
            stable <= '0;
        end else if (sw_sync != cand) begin
            cand   <= sw_sync;
            db_cnt <= '0;
        end else if (db_cnt == DB_MAX) begin
            stable <= cand;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (pending) state_nx = ARM;
            end
            ARM: begin
                if (!pending) begin
                    state_nx = RUN;
                end else if (bus.frame_done) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (bus.frame_done && !pending && f_cnt == F_MAX) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        do_swap   = 1'b0;
        do_unmute = 1'b0;
        do_count  = 1'b0;
        unique case (state)
            ARM: begin
                do_swap = bus.frame_done && pending;
            end
            HOLD: begin
                if (bus.frame_done) begin
                    if (pending) begin
                        do_swap = 1'b1;
                    end else if (f_cnt == F_MAX) begin
                        do_unmute = 1'b1;
                    end else begin
                        do_count = 1'b1;
                    end
                end
            end
            default: begin
                do_swap = 1'b0;
            end
        endcase
    end

    // a swap inside HOLD restarts the mute window from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_sel     <= '0;
            mute       <= 1'b0;
            sel_update <= 1'b0;
            f_cnt      <= '0;
        end else begin
            sel_update <= do_swap;
            if (do_swap) begin
                sw_sel <= stable;
                mute   <= 1'b1;
                f_cnt  <= '0;
            end else if (do_unmute) begin
                mute   <= 1'b0;
            end else if (do_count) begin
                f_cnt  <= f_cnt + FW'(1);
            end
        end
    end

    assign bus.sw_sel     = sw_sel;
    assign bus.mute       = mute;
    assign bus.sel_update = sel_update;
    assign bus.busy       = (state != RUN);
endmodule

// File: doc/fir_switch_sequencer.md
# fir_switch_sequencer

Control block that sequences filter-selection changes for the stereo FIR datapath. It debounces the board slide switches and applies a new filter selection to the FIR engine only at stereo-frame boundaries. Around each change it asserts a mute window of a fixed number of frames, so switching is click-free. It sits between the Basys-3 switch pins and the `sw` input of the FIR filter wrapper; its `mute` output gates the AXIS master data to zero.

## Interface
Parameters:
- `N_FILTERS`, 4 — number of filter-select switches; width of `sw_raw`/`sw_sel`.
- `DEBOUNCE_CYCLES`, 1_000_000 — stable cycles required before a switch change is accepted (10 ms at 100 MHz); legal range ≥ 2.
- `MUTE_FRAMES`, 64 — frames `mute` stays high after a selection swap; legal range ≥ 1.

Ports:
- `clk` in 1 — single system clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `sw_raw` in N_FILTERS — raw, asynchronous switch pins.
- `frame_done` in 1 — one pulse per completed stereo output frame (last-word AXIS master handshake); every high cycle counts as one frame.
- `sw_sel` out N_FILTERS — filter selection driven to the FIR engine; reset 0.
- `mute` out 1 — forces downstream output data to zero; reset 0.
- `sel_update` out 1 — one-cycle pulse in the cycle `sw_sel` takes a new value; reset 0.
- `busy` out 1 — high in every state except RUN; reset 0.

## Operation
- **Synchronizer:** two flops on `sw_raw` produce `sw_sync`. Reset clears both flops to 0.
- **Debouncer:**
  - `cand` register and `db_cnt` counter, width $clog2(DEBOUNCE_CYCLES).
  - If `sw_sync != cand`: `cand <= sw_sync`, `db_cnt <= 0`.
  - Else if `db_cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`; `db_cnt` saturates (no wrap).
  - Else: `db_cnt++`.
  - Reset clears `cand`, `db_cnt` and `stable` to 0.
- **FSM states:** RUN, ARM, HOLD. Reset state is RUN.
- **RUN:**
  - If `stable != sw_sel`, go to ARM. No other effect.
- **ARM** (`busy=1`, `mute` unchanged):
  - If `stable == sw_sel` (switch reverted before a boundary), return to RUN with no mute and no pulse.
  - Else on `frame_done`: `sw_sel <= stable`, `sel_update` pulse, `mute <= 1`, `f_cnt <= 0`, go to HOLD.
- **HOLD** (`busy=1`, `mute=1`):
  - On `frame_done` with `stable != sw_sel`: `sw_sel <= stable`, `sel_update` pulse, `f_cnt <= 0`, stay in HOLD (mute window restarts).
  - Else on `frame_done` with `f_cnt == MUTE_FRAMES-1`: `mute <= 0`, go to RUN.
  - Else on `frame_done`: `f_cnt++`.
  - `frame_done` absent: hold all state.
- **Counter width:** `f_cnt` is $clog2(MUTE_FRAMES+1) bits and never wraps.
- **Fixed rules:**
  - `sw_sel` changes only on a `frame_done` cycle.
  - `mute` rises in the same cycle `sw_sel` changes and falls only on a `frame_done`.
- **Reset mid-operation:** all outputs return to reset values in the next cycle, regardless of state.
  - Switches held non-zero through reset are re-accepted after the full sync plus debounce latency, then applied at the next frame boundary.

## Timing
- **`sw_raw` to `stable`:** a clean `sw_raw` step appears on `stable` 2 + DEBOUNCE_CYCLES cycles later. Any glitch restarts the count.
- **`stable` to ARM:** ARM is entered 1 cycle after `stable` updates.
- **Same-cycle `frame_done`:** a `frame_done` in the same cycle as the `stable` update or the RUN→ARM transition is not used. The swap waits for the next `frame_done` sampled in ARM.
- **Swap latency:** `sw_sel`, `mute` and `sel_update` are registered and change on the clock edge that samples the qualifying `frame_done`.
- **Mute window:** exactly MUTE_FRAMES `frame_done` pulses after the swap (the swap pulse itself excluded). `mute` falls on the edge sampling the MUTE_FRAMES-th pulse.
- **Back-to-back `frame_done`:** pulses on consecutive cycles are each counted.
- **No frame boundary:** if `frame_done` never arrives, the block stays in ARM/HOLD indefinitely. There is no timeout.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8, MUTE_FRAMES=4, N_FILTERS=4.

- **Reset values:** hold `reset` for 3 cycles with `sw_raw=4'b1111`, then release. Outputs read 0 until release; `stable` = 1111 at cycle 10 after release.
- **Basic swap:**
  - Stimulus: `sw_raw` 0000→0010, wait 12 cycles, then pulse `frame_done` every 20 cycles.
  - Required: `sw_sel=0010`, `sel_update` for 1 cycle and `mute=1` on the first pulse; `mute=0` on the 5th pulse; `busy` low afterwards.
- **Bounce rejection:**
  - Stimulus: toggle `sw_raw` bit0 every 5 cycles for 100 cycles, then hold 0000.
  - Required: `stable`, `sw_sel` and `mute` stay 0 throughout; `busy` never asserts.
- **Revert in ARM:**
  - Stimulus: accept 0100, then return `sw_raw` to 0000 for 10+ cycles before any `frame_done`.
  - Required: FSM goes RUN→ARM→RUN; `sw_sel` stays 0000; no `mute`, no `sel_update`.
- **Change during HOLD:**
  - Stimulus: swap to 0001, after 2 frames accept 1000.
  - Required: at the next `frame_done`, `sw_sel=1000` with a `sel_update` pulse and `f_cnt` restarted; `mute` stays high for 4 further frames, 7 muted frames in total.
- **Reset mid-HOLD:**
  - Stimulus: assert `reset` 1 cycle while `mute=1`, `sw_sel=0010`.
  - Required: next cycle `sw_sel=0`, `mute=0`, `busy=0`; `0010` is re-applied at the first `frame_done` ≥11 cycles after release, with the full 4-frame mute window.
